vga_dither_pwm: RTL
===================

Name: vga_dither_pwm

Overview:
- Parametrised temporal/spatial PWM ditherer for the analog VGA output path.
- Reduces each of three colour channels from IN_BITS to OUT_BITS. The dropped fraction is recovered by conditionally incrementing the kept MSBs on a rotating per-pixel phase.
- Per-line and per-frame phase rotation breaks up vertical stripe artefacts.
- Sits between the scaler/OSD mux and the VGA DAC pins; delays the sync signals so they stay aligned with the pixel data.

Parameters:
- IN_BITS, 8, input bits per channel.
- OUT_BITS, 6, DAC bits per channel kept. Must satisfy 1 <= OUT_BITS < IN_BITS.
- FRAC (localparam), IN_BITS-OUT_BITS, phase/fraction width.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  pixel clock enable; all state advances only when high.
- mode  in  1  0 = truncate (bypass dither), 1 = PWM dither.
- csync_en  in  1  1 = line timing taken from csync, 0 = from hsync.
- hsync  in  1  horizontal sync, active-high.
- vsync  in  1  vertical sync, active-high.
- csync  in  1  composite sync, active-high.
- din  in  3*IN_BITS  {R,G,B}, MSB channel R.
- dout  out  3*IN_BITS  {R,G,B}; per channel, top OUT_BITS carry the result and the low FRAC bits are driven 0.
- hs_out  out  1  hsync delayed to match dout.
- vs_out  out  1  vsync delayed to match dout.
- cs_out  out  1  csync delayed to match dout.

Behaviour:
- Reset (synchronous, wins over everything):
  - dout, hs_out, vs_out, cs_out = 0.
  - pix_ph, line_ph, frame_ph = 0.
  - Sync edge-detect registers = 0.
- Selected sync: ls = csync_en ? csync : hsync.
- All registers below update only on cycles with ce_pix=1. On other cycles they hold.
- pix_ph (FRAC bits):
  - Cleared to 0 while ls=1.
  - Increments by 1 mod 2^FRAC while ls=0.
- line_ph (FRAC bits): increments mod 2^FRAC on each ls 0->1 edge.
- frame_ph (FRAC bits):
  - Increments on each vsync 0->1 edge.
  - The same edge clears line_ph to 0; this clear has priority over a coincident ls edge.
- Effective phase: ph = (pix_ph + line_ph + frame_ph) mod 2^FRAC, computed combinationally from current register values. The first active pixel of a line therefore uses pix_ph=0.
- Per channel c:
  - hi = din_c[IN_BITS-1:FRAC], lo = din_c[FRAC-1:0].
  - mode=1: out_hi = hi+1 when (ph < lo) and (hi != all-ones); otherwise out_hi = hi. No wrap: saturates at all-ones.
  - mode=0: out_hi = hi.
  - dout_c = {out_hi, FRAC'b0}.
- Latency: exactly 1 ce_pix-qualified register stage for dout, hs_out, vs_out and cs_out together.
- mode and csync_en are sampled every ce_pix cycle; a change takes effect on the next registered output. There is no glitch requirement beyond that.
- Over 2^FRAC consecutive active pixels of constant value, the number of incremented pixels equals lo, unless saturated.
- Sync during active video: pix_ph clears immediately.
- Reset mid-line: after release, the first line starts with line_ph=frame_ph=0.

Optional Feature:
- Macro: VGA_DITHER_FRAME_EN.
- Defined: frame_ph behaves as specified above and vsync edges rotate the pattern per frame.
- Undefined:
  - frame_ph is removed and treated as constant 0.
  - vsync edges still clear line_ph.
  - vs_out is still delayed.

Test Plan:
- IN_BITS=8, OUT_BITS=6, mode=0, R=0x8B, ce_pix=1 -> dout R=0x88 one cycle later for every pixel; hs_out/vs_out track inputs with 1-cycle delay.
- mode=1, first line after reset, R=0x8B (lo=3), four active pixels -> R outputs 0x8C,0x8C,0x8C,0x88. G=0x00 -> 0x00 throughout.
- mode=1, R=0xFF -> always 0xFC, never wraps. R=0xFC -> always 0xFC.
- mode=1, second line (one ls 0->1 edge, line_ph=1), R=0x81 (lo=1), four pixels -> 0x80,0x80,0x80,0x84. After a vsync 0->1 edge with VGA_DITHER_FRAME_EN, first line pixel0 uses ph=1 -> 0x80.
- ce_pix toggling 1,0,0,1 with changing din -> dout, pix_ph and sync outs hold on ce_pix=0 cycles; the phase sequence is unaffected by the gaps.
- Assert reset for one cycle mid-line during dither -> next cycle dout=0 and sync outs=0. After release the pattern restarts at ph=0 (R=0x8B gives 0x8C first).

Source files
------------

// File: rtl/vga_dither_pwm_if.sv
// Pixel/sync bundle for the VGA PWM ditherer.
//   master : pixel source (drives ce_pix, mode, csync_en, syncs, din; observes outputs)
//   slave  : ditherer (consumes inputs, drives dout and delayed syncs)
interface vga_dither_pwm_if #(
  parameter int unsigned IN_BITS = 8
);
  logic                   ce_pix;
  logic                   mode;
  logic                   csync_en;
  logic                   hsync;
  logic                   vsync;
  logic                   csync;
  logic [3*IN_BITS-1:0]   din;
  logic [3*IN_BITS-1:0]   dout;
  logic                   hs_out;
  logic                   vs_out;
  logic                   cs_out;

  modport master (
    output ce_pix, mode, csync_en, hsync, vsync, csync, din,
    input  dout, hs_out, vs_out, cs_out
  );

  modport slave (
    input  ce_pix, mode, csync_en, hsync, vsync, csync, din,
    output dout, hs_out, vs_out, cs_out
  );
endinterface

// File: rtl/vga_dither_pwm.sv
// Temporal/spatial PWM ditherer for the analog VGA DAC path.
// Reduces each RGB channel from IN_BITS to OUT_BITS, recovering the dropped
// fraction by bumping the kept MSBs on a rotating pixel/line/frame phase.
// Optional macro VGA_DITHER_FRAME_EN enables per-frame phase rotation.
// Ports:
//   clk   : pixel/system clock
//   reset : synchronous active-high reset
//   bus   : vga_dither_pwm_if.slave (ce_pix, mode, csync_en, hsync, vsync,
//           csync, din in; dout, hs_out, vs_out, cs_out out, 1-stage latency)
module vga_dither_pwm #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  vga_dither_pwm_if.slave  bus
);

  localparam int unsigned FRAC = IN_BITS - OUT_BITS;
  localparam int unsigned DW   = 3 * IN_BITS;

  if (OUT_BITS < 1 || OUT_BITS >= IN_BITS) begin : g_param_check
    $error("vga_dither_pwm: OUT_BITS must satisfy 1 <= OUT_BITS < IN_BITS");
  end

  logic [FRAC-1:0] pix_ph;
  logic [FRAC-1:0] line_ph;
  logic [FRAC-1:0] frame_ph;
  logic            ls_q;
  logic            vs_q;
  logic [DW-1:0]   dout_q;
  logic            hs_q;
  logic            vs_out_q;
  logic            cs_q;

  logic            ls_c;
  logic            ls_rise_c;
  logic            vs_rise_c;
  logic [FRAC-1:0] ph_c;
  logic [DW-1:0]   dith_c;

  // Line timing source and sync edge detection
  assign ls_c      = bus.csync_en ? bus.csync : bus.hsync;
  assign ls_rise_c = ls_c & ~ls_q;
  assign vs_rise_c = bus.vsync & ~vs_q;

  // Effective phase wraps naturally at FRAC bits
  assign ph_c = FRAC'(pix_ph + line_ph + frame_ph);

  // Per-channel conditional increment of the kept MSBs, saturating at all-ones
  always_comb begin
    dith_c = '0;
    for (int c = 0; c < 3; c++) begin
      logic [OUT_BITS-1:0] hi;
      logic [FRAC-1:0]     lo;
      hi = bus.din[c*IN_BITS+FRAC +: OUT_BITS];
      lo = bus.din[c*IN_BITS +: FRAC];
      if (bus.mode && (ph_c < lo) && (hi != '1)) begin
        hi = hi + OUT_BITS'(1);
      end
      dith_c[c*IN_BITS+FRAC +: OUT_BITS] = hi;
    end
  end

  // Phase counters and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_ph  <= '0;
      line_ph <= '0;
      ls_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else if (bus.ce_pix) begin
      pix_ph <= ls_c ? '0 : FRAC'(pix_ph + FRAC'(1));
      // A new frame restarts the line phase, overriding a coincident line edge
      if (vs_rise_c) begin
        line_ph <= '0;
      end else if (ls_rise_c) begin
        line_ph <= FRAC'(line_ph + FRAC'(1));
      end
      ls_q <= ls_c;
      vs_q <= bus.vsync;
    end
  end

`ifdef VGA_DITHER_FRAME_EN
  // Per-frame rotation of the dither pattern
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_ph <= '0;
    end else if (bus.ce_pix && vs_rise_c) begin
      frame_ph <= FRAC'(frame_ph + FRAC'(1));
    end
  end
`else
  assign frame_ph = '0;
`endif

  // Single output stage keeps pixels and syncs aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q   <= '0;
      hs_q     <= 1'b0;
      vs_out_q <= 1'b0;
      cs_q     <= 1'b0;
    end else if (bus.ce_pix) begin
      dout_q   <= dith_c;
      hs_q     <= bus.hsync;
      vs_out_q <= bus.vsync;
      cs_q     <= bus.csync;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.hs_out = hs_q;
  assign bus.vs_out = vs_out_q;
  assign bus.cs_out = cs_q;

endmodule
